// File: rtl/axil_sram_bridge.sv
// AXI4-Lite slave to simple SRAM request/response bridge, one transaction in flight.
// Optional watchdog on the SRAM request phase: define AXIL_SRAM_BRIDGE_TIMEOUT_EN.
module axil_sram_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    // AXI4-Lite read channel
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    // AXI4-Lite write channel
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // SRAM side
    output logic [ADDR_WIDTH-1:0]   mem_araddr,
    output logic                    mem_ren,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic [1:0]              mem_rresp,
    input  logic                    mem_rvalid,
    output logic [ADDR_WIDTH-1:0]   mem_awaddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_wen,
    input  logic [1:0]              mem_bresp,
    input  logic                    mem_bvalid
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        WR_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_araddr_q, mem_araddr_d;
    logic [ADDR_WIDTH-1:0]   mem_awaddr_q, mem_awaddr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    mem_ren_q, mem_ren_d;
    logic                    mem_wen_q, mem_wen_d;
    logic                    rvalid_q, rvalid_d;
    logic                    bvalid_q, bvalid_d;

    logic mem_idle;
    logic can_accept;
    logic wr_accept;
    logic rd_accept;
    logic timeout;

    // A response still on the SRAM bus belongs to the previous access, so new work waits.
    assign mem_idle   = !mem_rvalid && !mem_bvalid;
    assign can_accept = !rst && (state_q == IDLE) && mem_idle;

    // Write wins a tie; AW and W are only ever taken together.
    assign awready   = can_accept && awvalid && wvalid;
    assign wready    = can_accept && awvalid && wvalid;
    assign arready   = can_accept && !(awvalid && wvalid);
    assign wr_accept = awready;
    assign rd_accept = arready && arvalid;

`ifdef AXIL_SRAM_BRIDGE_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q;

    // Cleared while idle, so every request phase starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == IDLE) begin
            timer_q <= '0;
        end else if ((state_q == RD_REQ || state_q == WR_REQ) && !timeout) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign timeout = (timer_q == TIMER_LAST);
`else
    // Watchdog compiled out: the request phase waits for the SRAM forever.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        mem_araddr_d = mem_araddr_q;
        mem_awaddr_d = mem_awaddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        bresp_d      = bresp_q;

        unique case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    mem_awaddr_d = awaddr;
                    mem_wdata_d  = wdata;
                    mem_wstrb_d  = wstrb;
                    state_d      = WR_REQ;
                end else if (rd_accept) begin
                    mem_araddr_d = araddr;
                    state_d      = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    rresp_d = mem_rresp;
                    state_d = RD_RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    rresp_d = 2'b10;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_bvalid) begin
                    bresp_d = mem_bresp;
                    state_d = WR_RESP;
                end else if (timeout) begin
                    bresp_d = 2'b10;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes and valids are registered copies of the next state, so they never glitch.
        mem_ren_d = (state_d == RD_REQ);
        mem_wen_d = (state_d == WR_REQ);
        rvalid_d  = (state_d == RD_RESP);
        bvalid_d  = (state_d == WR_RESP);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_araddr_q <= '0;
            mem_awaddr_q <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            bresp_q      <= '0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            bvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_araddr_q <= mem_araddr_d;
            mem_awaddr_q <= mem_awaddr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            bresp_q      <= bresp_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            rvalid_q     <= rvalid_d;
            bvalid_q     <= bvalid_d;
        end
    end

    assign mem_araddr = mem_araddr_q;
    assign mem_awaddr = mem_awaddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_ren    = mem_ren_q;
    assign mem_wen    = mem_wen_q;
    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign rvalid     = rvalid_q;
    assign bresp      = bresp_q;
    assign bvalid     = bvalid_q;

endmodule
